// File: rtl/ahb_arb_pkg.sv
// rtl/ahb_arb_pkg.sv - shared types, constants and burst helper for the AHB arbiter
// Contents: htrans_t, hburst_t, ARB_FIXED/ARB_RR, burst_beats().
package ahb_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_t;

  // Beats still to come after the NONSEQ beat. Undefined-length INCR and
  // SINGLE report 0 so the arbiter may hand over at any beat.
  function automatic logic [4:0] burst_beats(input hburst_t burst);
    logic [2:0] b;
    b = burst;
    case (b[2:1])
      2'b01:   burst_beats = 5'd3;
      2'b10:   burst_beats = 5'd7;
      2'b11:   burst_beats = 5'd15;
      default: burst_beats = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// rtl/ahb_arb_pick.sv - rotating priority picker (search upward from base+1 with wrap)
// Ports: req_i requests, base_i last winner, gnt_o one-hot winner,
//        idx_o winner index, valid_o any request present.
module ahb_arb_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] base_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  always_comb begin
    int   cand;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(base_i) + 1 + i) % N;
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = W'(cand);
        found       = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - AHB bus arbiter with burst/lock-aware re-arbitration
// Ports: clk, rst (sync, active-high); HBUSREQ/HLOCK per-master requests;
//        HTRANS/HBURST/HREADY muxed bus status; HGRANT one-hot grant;
//        HMASTER address-phase owner; HMASTLOCK locked phase; HMASTER_D data-phase owner.
module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter  int NUM_MASTERS    = 4,
  parameter  int DEFAULT_MASTER = 0,
  parameter  int ARB_MODE       = 1,
  localparam int MASTER_BITS    = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MASTER_BITS-1:0] HMASTER,
  output logic                   HMASTLOCK,
  output logic [MASTER_BITS-1:0] HMASTER_D
);

  localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MASTER_BITS-1:0] DEF_IDX = MASTER_BITS'(DEFAULT_MASTER);

  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [MASTER_BITS-1:0] hmaster_q, hmaster_d;
  logic [MASTER_BITS-1:0] hmaster_dp_q, hmaster_dp_d;
  logic [MASTER_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic                   hmastlock_q, hmastlock_d;
  logic [4:0]             rem_q, rem_d;

  logic [MASTER_BITS-1:0] gnt_idx;
  logic [MASTER_BITS-1:0] pick_base;
  logic [MASTER_BITS-1:0] pick_idx;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic                   pick_valid;
  logic                   rearb_ok;

  // Index of the currently granted master (grant is always one-hot).
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hgrant_q[i]) gnt_idx = MASTER_BITS'(i);
    end
  end

  // Fixed priority is the rotating search pinned to start at index 0.
  assign pick_base = (ARB_MODE == ARB_RR) ? rr_ptr_q : MASTER_BITS'(NUM_MASTERS - 1);

  ahb_arb_pick #(
    .N (NUM_MASTERS),
    .W (MASTER_BITS)
  ) u_pick (
    .req_i   (HBUSREQ),
    .base_i  (pick_base),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    hgrant_d     = hgrant_q;
    hmaster_d    = hmaster_q;
    hmaster_dp_d = hmaster_dp_q;
    hmastlock_d  = hmastlock_q;
    rr_ptr_d     = rr_ptr_q;
    rem_d        = rem_q;
    rearb_ok     = 1'b0;

    if (HREADY) begin
      case (htrans_t'(HTRANS))
        HTRANS_NONSEQ: rem_d = burst_beats(hburst_t'(HBURST));
        HTRANS_SEQ:    rem_d = (rem_q != 5'd0) ? rem_q - 5'd1 : rem_q;
        HTRANS_IDLE:   rem_d = 5'd0;
        HTRANS_BUSY:   rem_d = rem_q;
      endcase

      hmaster_d    = gnt_idx;
      hmastlock_d  = HLOCK[gnt_idx];
      hmaster_dp_d = hmaster_q;

      // Hand over only once the burst is down to its last address beat
      // (rem<=1 after this edge) and the owner is not holding a lock.
      rearb_ok = (rem_d <= 5'd1) && !HLOCK[gnt_idx];
    end

    if (rearb_ok) begin
      if (pick_valid) begin
        hgrant_d = pick_gnt;
        rr_ptr_d = pick_idx;
      end else begin
        hgrant_d = DEF_GNT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hgrant_q     <= DEF_GNT;
      hmaster_q    <= DEF_IDX;
      hmaster_dp_q <= DEF_IDX;
      hmastlock_q  <= 1'b0;
      rem_q        <= 5'd0;
      rr_ptr_q     <= DEF_IDX;
    end else begin
      hgrant_q     <= hgrant_d;
      hmaster_q    <= hmaster_d;
      hmaster_dp_q <= hmaster_dp_d;
      hmastlock_q  <= hmastlock_d;
      rem_q        <= rem_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign HGRANT    = hgrant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;
  assign HMASTER_D = hmaster_dp_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - directed self-checking bench for ahb_arbiter
module tb_ahb_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] HBUSREQ, HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER, HMASTER_D;
  logic       HMASTLOCK;

  logic [3:0] breq_b, block_b;
  logic [1:0] btrans_b;
  logic [2:0] bburst_b;
  logic       bready_b;
  logic [3:0] gnt_b;
  logic [1:0] hm_b, hmd_b;
  logic       hml_b;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0), .ARB_MODE(1)) u_dut (
    .clk(clk), .rst(rst), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HTRANS(HTRANS),
    .HBURST(HBURST), .HREADY(HREADY), .HGRANT(HGRANT), .HMASTER(HMASTER),
    .HMASTLOCK(HMASTLOCK), .HMASTER_D(HMASTER_D)
  );

  ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(2), .ARB_MODE(0)) u_fix (
    .clk(clk), .rst(rst), .HBUSREQ(breq_b), .HLOCK(block_b), .HTRANS(btrans_b),
    .HBURST(bburst_b), .HREADY(bready_b), .HGRANT(gnt_b), .HMASTER(hm_b),
    .HMASTLOCK(hml_b), .HMASTER_D(hmd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait-state section table: ready, trans, req, exp grant, exp rem, exp HMASTER, exp HMASTER_D
  logic       ws_rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [1:0] ws_tr  [7] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
  logic [3:0] ws_req [7] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0001};
  logic [3:0] ws_gnt [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0001};
  logic [4:0] ws_rem [7] = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd2, 5'd1, 5'd0};
  logic [1:0] ws_hm  [7] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
  logic [1:0] ws_md  [7] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};

  initial begin
    rst = 1'b1; HBUSREQ = 4'b0000; HLOCK = 4'b0000; HTRANS = 2'b00;
    HBURST = 3'b000; HREADY = 1'b1;
    breq_b = 4'b0000; block_b = 4'b0000; btrans_b = 2'b00; bburst_b = 3'b000; bready_b = 1'b1;

    // Reset for two edges
    tick(); tick();
    check("rst_hgrant", 32'(HGRANT), 32'h1);
    check("rst_hmaster", 32'(HMASTER), 32'h0);
    check("rst_hmaster_d", 32'(HMASTER_D), 32'h0);
    check("rst_hmastlock", 32'(HMASTLOCK), 32'h0);
    check("rst_fix_hgrant", 32'(gnt_b), 32'h4);
    check("rst_fix_hmaster", 32'(hm_b), 32'h2);
    rst = 1'b0;

    // Idle bus: both stay on their default masters
    tick();
    check("idle_hgrant", 32'(HGRANT), 32'h1);
    check("idle_fix_hgrant", 32'(gnt_b), 32'h4);

    // Round-robin with 1011 held, SINGLE NONSEQ each cycle; fixed instance in parallel
    HBUSREQ = 4'b1011; HTRANS = 2'b10; HBURST = 3'b000;
    breq_b = 4'b1010;
    tick();
    check("rr1_hgrant", 32'(HGRANT), 32'h2);
    check("rr1_hmaster", 32'(HMASTER), 32'h0);
    check("fix1_hgrant", 32'(gnt_b), 32'h2);
    breq_b = 4'b1100;
    tick();
    check("rr2_hgrant", 32'(HGRANT), 32'h8);
    check("rr2_hmaster", 32'(HMASTER), 32'h1);
    check("rr2_hmaster_d", 32'(HMASTER_D), 32'h0);
    check("fix2_hgrant", 32'(gnt_b), 32'h4);
    check("fix2_hmaster", 32'(hm_b), 32'h1);
    breq_b = 4'b0000;
    tick();
    check("rr3_hgrant", 32'(HGRANT), 32'h1);
    check("rr3_hmaster", 32'(HMASTER), 32'h3);
    check("rr3_hmaster_d", 32'(HMASTER_D), 32'h1);
    check("fix3_default", 32'(gnt_b), 32'h4);

    // M1 alone: granted, then keeps the grant
    HBUSREQ = 4'b0010; HTRANS = 2'b00;
    tick();
    check("m1_hgrant", 32'(HGRANT), 32'h2);
    tick();
    check("m1_keep_hgrant", 32'(HGRANT), 32'h2);
    check("m1_keep_hmaster", 32'(HMASTER), 32'h1);

    // INCR8 by M1 while M2 requests; grant moves at the 7th beat's edge
    HBURST = 3'b101;
    for (int beat = 1; beat <= 8; beat++) begin
      HTRANS  = (beat == 1) ? 2'b10 : 2'b11;
      HBUSREQ = (beat == 8) ? 4'b0100 : 4'b0110;
      tick();
      check($sformatf("incr8_b%0d_hgrant", beat), 32'(HGRANT), (beat >= 7) ? 32'h4 : 32'h2);
      check($sformatf("incr8_b%0d_rem", beat), 32'(u_dut.rem_q), 32'(8 - beat));
      check($sformatf("incr8_b%0d_hmaster", beat), 32'(HMASTER), (beat == 8) ? 32'h2 : 32'h1);
      check($sformatf("incr8_b%0d_hmaster_d", beat), 32'(HMASTER_D), 32'h1);
    end

    // INCR4 by M2 with three wait states on beat 2
    HBURST = 3'b011;
    for (int s = 0; s < 7; s++) begin
      HREADY = ws_rdy[s]; HTRANS = ws_tr[s]; HBUSREQ = ws_req[s];
      tick();
      check($sformatf("ws%0d_hgrant", s), 32'(HGRANT), 32'(ws_gnt[s]));
      check($sformatf("ws%0d_rem", s), 32'(u_dut.rem_q), 32'(ws_rem[s]));
      check($sformatf("ws%0d_hmaster", s), 32'(HMASTER), 32'(ws_hm[s]));
      check($sformatf("ws%0d_hmaster_d", s), 32'(HMASTER_D), 32'(ws_md[s]));
    end
    HREADY = 1'b1;

    // Locked sequence by M3 while M0 requests
    HBURST = 3'b000; HTRANS = 2'b00; HBUSREQ = 4'b1000; HLOCK = 4'b1000;
    tick();
    check("lk0_hgrant", 32'(HGRANT), 32'h8);
    check("lk0_hmastlock", 32'(HMASTLOCK), 32'h0);
    HBUSREQ = 4'b1001; HTRANS = 2'b10;
    for (int t = 1; t <= 5; t++) begin
      tick();
      check($sformatf("lk%0d_hgrant", t), 32'(HGRANT), 32'h8);
      check($sformatf("lk%0d_hmastlock", t), 32'(HMASTLOCK), 32'h1);
      check($sformatf("lk%0d_hmaster", t), 32'(HMASTER), 32'h3);
    end
    HLOCK = 4'b0000; HTRANS = 2'b00;
    tick();
    check("unlk_hgrant", 32'(HGRANT), 32'h1);
    check("unlk_hmastlock", 32'(HMASTLOCK), 32'h0);

    // Reset mid-burst and mid-lock, with HREADY low
    HBUSREQ = 4'b0011; HLOCK = 4'b0001; HTRANS = 2'b10; HBURST = 3'b111;
    tick();
    check("pre_rst_rem", 32'(u_dut.rem_q), 32'd15);
    check("pre_rst_hmastlock", 32'(HMASTLOCK), 32'h1);
    check("pre_rst_hmaster_d", 32'(HMASTER_D), 32'h3);
    rst = 1'b1; HREADY = 1'b0; HTRANS = 2'b11;
    tick();
    check("mid_rst_rem", 32'(u_dut.rem_q), 32'd0);
    check("mid_rst_hmastlock", 32'(HMASTLOCK), 32'h0);
    check("mid_rst_hmaster_d", 32'(HMASTER_D), 32'h0);
    check("mid_rst_hgrant", 32'(HGRANT), 32'h1);
    rst = 1'b0; HREADY = 1'b1; HLOCK = 4'b0000; HBUSREQ = 4'b0010; HTRANS = 2'b00;
    tick();
    check("post_rst_hgrant", 32'(HGRANT), 32'h2);

    // Owner drops while another raises on the same edge
    HBUSREQ = 4'b0100;
    tick();
    check("swap_hgrant", 32'(HGRANT), 32'h4);
    check("swap_hmaster", 32'(HMASTER), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
